// File: rtl/mcu_spi.sv
// SPI slave (mode 0, MSB first) oversampled in the system clock domain.
// Turns each transfer into a target byte plus strobed payload bytes, and shifts a reply byte back on MISO.
module mcu_spi #(
   parameter logic [7:0] TGT_SYS  = 8'h01,
   parameter logic [7:0] TGT_HID  = 8'h02,
   parameter logic [7:0] TGT_OSD  = 8'h03,
   parameter logic [7:0] REPLY_ID = 8'h5C
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       spi_io_ss,
   input  logic       spi_io_clk,
   input  logic       spi_io_din,
   output logic       spi_io_dout,
   input  logic [7:0] mcu_reply,
   output logic [7:0] mcu_data,
   output logic       mcu_start,
   output logic       mcu_sys_strobe,
   output logic       mcu_hid_strobe,
   output logic       mcu_osd_strobe
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TARGET,
      ST_PAYLOAD
   } state_t;

   // [0] first sync stage, [1] synchronised value, [2] history
   logic [2:0] ss_q, ss_d;
   logic [2:0] sclk_q, sclk_d;
   logic [1:0] din_q, din_d;

   logic [1:0] flush_q, flush_d;
   logic       armed_q, armed_d;
   state_t     state_q, state_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic [7:0] rx_q, rx_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] target_q, target_d;
   logic       first_q, first_d;
   logic [7:0] data_q, data_d;
   logic       sys_q, sys_d;
   logic       hid_q, hid_d;
   logic       osd_q, osd_d;
   logic       start_q, start_d;

   logic       rise, fall, ss_fall;
   logic [7:0] rx_byte;
   logic       hit_sys, hit_hid, hit_osd;

   assign rise    = sclk_q[1] & ~sclk_q[2];
   assign fall    = ~sclk_q[1] & sclk_q[2];
   assign ss_fall = ss_q[2] & ~ss_q[1];
   assign rx_byte = {rx_q[6:0], din_q[1]};

   assign hit_sys = (target_q == TGT_SYS);
   assign hit_hid = (target_q == TGT_HID);
   assign hit_osd = (target_q == TGT_OSD);

   always_comb begin
      // NOTE: every *_d gets a default first so no path through this block can infer a latch.
      ss_d     = {ss_q[1:0], spi_io_ss};
      sclk_d   = {sclk_q[1:0], spi_io_clk};
      din_d    = {din_q[0], spi_io_din};
      flush_d  = {flush_q[0], 1'b1};
      // Arm only once ss has been genuinely observed high after reset, so a
      // transfer already running at reset release is ignored.
      armed_d  = armed_q | (flush_q[1] & ss_q[1]);
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      rx_d     = rx_q;
      tx_d     = tx_q;
      target_d = target_q;
      first_d  = first_q;
      data_d   = data_q;
      sys_d    = 1'b0;
      hid_d    = 1'b0;
      osd_d    = 1'b0;
      start_d  = 1'b0;

      if (ss_q[1]) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ss_fall && armed_q) begin
                  state_d  = ST_TARGET;
                  bitcnt_d = 3'd0;
                  rx_d     = 8'h00;
                  tx_d     = REPLY_ID;
               end
            end
            default: begin
               if (rise) begin
                  rx_d     = rx_byte;
                  bitcnt_d = bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) begin
                     tx_d = mcu_reply;
                     if (state_q == ST_TARGET) begin
                        target_d = rx_byte;
                        first_d  = 1'b1;
                        state_d  = ST_PAYLOAD;
                     end else if (hit_sys || hit_hid || hit_osd) begin
                        data_d  = rx_byte;
                        sys_d   = hit_sys;
                        hid_d   = hit_hid;
                        osd_d   = hit_osd;
                        start_d = first_q;
                        first_d = 1'b0;
                     end
                  end
               end else if (fall && (bitcnt_q != 3'd0)) begin
                  // The fall right after a completed byte keeps the fresh reply MSB.
                  tx_d = {tx_q[6:0], 1'b0};
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ss_q     <= 3'b111;
         sclk_q   <= 3'b000;
         din_q    <= 2'b00;
         flush_q  <= 2'b00;
         armed_q  <= 1'b0;
         state_q  <= ST_IDLE;
         bitcnt_q <= 3'd0;
         rx_q     <= 8'h00;
         tx_q     <= 8'h00;
         target_q <= 8'h00;
         first_q  <= 1'b0;
         data_q   <= 8'h00;
         sys_q    <= 1'b0;
         hid_q    <= 1'b0;
         osd_q    <= 1'b0;
         start_q  <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
         ss_q     <= ss_d;
         sclk_q   <= sclk_d;
         din_q    <= din_d;
         flush_q  <= flush_d;
         armed_q  <= armed_d;
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         rx_q     <= rx_d;
         tx_q     <= tx_d;
         target_q <= target_d;
         first_q  <= first_d;
         data_q   <= data_d;
         sys_q    <= sys_d;
         hid_q    <= hid_d;
         osd_q    <= osd_d;
         start_q  <= start_d;
      end
   end

   assign spi_io_dout    = tx_q[7];
   assign mcu_data       = data_q;
   assign mcu_start      = start_q;
   assign mcu_sys_strobe = sys_q;
   assign mcu_hid_strobe = hid_q;
   assign mcu_osd_strobe = osd_q;

endmodule

// File: tb/tb_mcu_spi.sv
// Self-checking bench for mcu_spi: directed transfers plus a randomised 256-byte
// OSD burst, checked against a transfer-level model of targets, payloads and replies.
`timescale 1ns/1ps
module tb_mcu_spi;

   localparam int HALF = 40;   // SCLK half period: 4 system clocks

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       spi_io_ss = 1'b1;
   logic       spi_io_clk = 1'b0;
   logic       spi_io_din = 1'b0;
   logic [7:0] mcu_reply = 8'h00;
   logic       spi_io_dout;
   logic [7:0] mcu_data;
   logic       mcu_start;
   logic       mcu_sys_strobe;
   logic       mcu_hid_strobe;
   logic       mcu_osd_strobe;

   mcu_spi dut (
      .clk            (clk),
      .reset          (reset),
      .spi_io_ss      (spi_io_ss),
      .spi_io_clk     (spi_io_clk),
      .spi_io_din     (spi_io_din),
      .spi_io_dout    (spi_io_dout),
      .mcu_reply      (mcu_reply),
      .mcu_data       (mcu_data),
      .mcu_start      (mcu_start),
      .mcu_sys_strobe (mcu_sys_strobe),
      .mcu_hid_strobe (mcu_hid_strobe),
      .mcu_osd_strobe (mcu_osd_strobe)
   );

   always #5 clk = ~clk;

   // tgt is one-hot {sys, hid, osd}
   typedef struct {
      logic [2:0] tgt;
      logic [7:0] data;
      logic       start;
   } ev_t;

   ev_t        got_q[$];
   ev_t        exp_q[$];
   ev_t        mon_e;
   logic [7:0] xb[$];
   logic [7:0] rep[$];
   logic [7:0] miso_q[$];
   logic [7:0] last_data;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         jit = 0;

   // Every cycle carrying a strobe or a start is recorded as one event.
   always @(negedge clk) begin
      if (!reset && (mcu_sys_strobe || mcu_hid_strobe || mcu_osd_strobe || mcu_start)) begin
         mon_e.tgt   = {mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe};
         mon_e.data  = mcu_data;
         mon_e.start = mcu_start;
         got_q.push_back(mon_e);
      end
   end

   initial begin
      #2ms;
      $display("FAIL timeout: bench did not finish, got 0 expected 1");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int half_len();
      return HALF + ((jit != 0) ? int'($urandom_range(0, 3)) : 0);
   endfunction

   // Master side, mode 0: data set up while SCLK low, MISO sampled just before the rise.
   task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int k = 0; k < nbits; k++) begin
         spi_io_din = tx[7-k];
         #(half_len());
         rx[7-k] = spi_io_dout;
         spi_io_clk = 1'b1;
         #(half_len());
         spi_io_clk = 1'b0;
      end
   endtask

   // Sends xb with rep[j] presented on mcu_reply during byte j; the last byte is cut to 'cut' bits.
   task automatic xfer(input int cut);
      logic [7:0] r;
      int         nb;
      miso_q.delete();
      got_q.delete();
      if (jit != 0) #($urandom_range(1, 9));
      spi_io_ss = 1'b0;
      #(2*HALF);
      for (int j = 0; j < xb.size(); j++) begin
         mcu_reply = rep[j];
         nb = (j == xb.size() - 1) ? cut : 8;
         spi_bits(xb[j], nb, r);
         if (nb == 8) miso_q.push_back(r);
      end
      #(HALF);
      spi_io_ss = 1'b1;
      #(3*HALF);
   endtask

   // Transfer-level model: byte 0 names the target, each later complete byte is a payload.
   task automatic build_expect(input int cut);
      int         nfull;
      logic       first;
      logic [2:0] code;
      ev_t        e;
      nfull = (cut == 8) ? xb.size() : xb.size() - 1;
      first = 1'b1;
      exp_q.delete();
      case (xb[0])
         8'h01:   code = 3'b100;
         8'h02:   code = 3'b010;
         8'h03:   code = 3'b001;
         default: code = 3'b000;
      endcase
      for (int i = 1; i < nfull; i++) begin
         if (code != 3'b000) begin
            e.tgt   = code;
            e.data  = xb[i];
            e.start = first;
            exp_q.push_back(e);
            first     = 1'b0;
            last_data = xb[i];
         end
      end
   endtask

   task automatic cmp_events(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         check($sformatf("%s_tgt%0d", tag, i), got_q[i].tgt, exp_q[i].tgt);
         check($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i].data);
         check($sformatf("%s_start%0d", tag, i), got_q[i].start, exp_q[i].start);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_miso(input string tag);
      for (int j = 0; j < miso_q.size(); j++)
         check($sformatf("%s_miso%0d", tag, j), miso_q[j], (j == 0) ? 8'h5C : rep[j-1]);
   endtask

   initial begin
      logic [7:0] r;
      int         nstart;
      last_data = 8'h00;

      // Reset state
      #23;
      check("rst_data", mcu_data, 8'h00);
      check("rst_miso", spi_io_dout, 1'b0);
      check("rst_flags", {mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_start}, 4'h0);
      reset = 1'b0;
      #(3*HALF);

      // OSD transfer with a constant reply byte
      xb = '{8'h03, 8'hA1, 8'hB2};
      rep = '{8'h77, 8'h77, 8'h77};
      xfer(8);
      build_expect(8);
      cmp_events("osd");
      check_miso("osd");
      check("osd_data_hold", mcu_data, 8'hB2);

      // Unknown target: silent
      xb = '{8'h07, 8'h11, 8'h22};
      rep = '{8'h3C, 8'hC3, 8'h99};
      xfer(8);
      build_expect(8);
      cmp_events("unk");
      check_miso("unk");
      check("unk_data_hold", mcu_data, 8'hB2);

      // Partial byte dropped, then a clean SYS transfer
      xb = '{8'h01, 8'hC3};
      rep = '{8'h12, 8'h34};
      xfer(5);
      build_expect(5);
      cmp_events("part");
      xb = '{8'h01, 8'hD4};
      rep = '{8'hF0, 8'h0F};
      xfer(8);
      build_expect(8);
      cmp_events("sys");
      check("sys_data", mcu_data, 8'hD4);

      // Reset mid-byte while ss stays low
      got_q.delete();
      spi_io_ss = 1'b0;
      #(2*HALF);
      spi_bits(8'h02, 1, r);
      #(HALF);
      check("pre_reset_miso", spi_io_dout, 1'b1);
      reset = 1'b1;
      #1;
      check("mid_rst_data", mcu_data, 8'h00);
      check("mid_rst_miso", spi_io_dout, 1'b0);
      check("mid_rst_flags", {mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_start}, 4'h0);
      #30;
      reset = 1'b0;
      spi_bits(8'h04, 7, r);
      spi_bits(8'h02, 8, r);
      spi_bits(8'hE5, 8, r);
      #(2*HALF);
      check("held_ss_events", got_q.size(), 0);
      check("held_ss_data", mcu_data, 8'h00);
      spi_io_ss = 1'b1;
      #(3*HALF);
      xb = '{8'h02, 8'hE5};
      rep = '{8'hAB, 8'hCD};
      xfer(8);
      build_expect(8);
      cmp_events("hid");
      check_miso("hid");
      check("hid_data", mcu_data, 8'hE5);

      // Randomised 256-byte OSD burst with phase jitter
      jit = 1;
      xb.delete();
      rep.delete();
      xb.push_back(8'h03);
      rep.push_back(8'($urandom));
      for (int i = 0; i < 256; i++) begin
         xb.push_back(8'($urandom));
         rep.push_back(8'($urandom));
      end
      xfer(8);
      build_expect(8);
      nstart = 0;
      foreach (got_q[i]) if (got_q[i].start) nstart++;
      check("rnd_starts", nstart, 1);
      check("rnd_strobes", got_q.size(), 256);
      cmp_events("rnd");
      check_miso("rnd");
      check("rnd_last_data", mcu_data, last_data);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
